operand_latch: RTL and testbench
================================

OPERAND_LATCH -- requirements
Module: operand_latch

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synchronized cycles required to accept a KEY1 edge (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 SHALL have port MAX10_CLK1_50  input  1  sole clock; all state rises on its rising edge.
REQ-003 SHALL have port KEY0  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port KEY1  input  1  capture pushbutton, active-low, asynchronous to clock, bouncy.
REQ-005 SHALL have port SW  input  8  operand switches, asynchronous to clock.
REQ-006 SHALL have port X  output  4  captured operand A (SW[3:0]).
REQ-007 SHALL have port Y  output  4  captured operand B (SW[7:4]).
REQ-008 SHALL have port valid  output  1  one-cycle pulse; X/Y newly captured.
REQ-009 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-010 SHALL have port capture_count  output  4  number of captures since reset, modulo 16.

Function
REQ-011 SHALL pass KEY1 and SW each through a 2-flop synchronizer; all logic uses synchronized values only (key_s, sw_s).
REQ-012 SHALL implement FSM states IDLE, DB_PRESS, HELD, DB_RELEASE.
REQ-013 IDLE: key_s=0 -> DB_PRESS with debounce counter cleared to 0; else stay.
REQ-014 DB_PRESS: key_s=0 -> counter+1; key_s=1 -> IDLE, counter cleared, no capture.
REQ-015 DB_PRESS: on the cycle key_s=0 and counter = DEBOUNCE_CYCLES-1 -> HELD and capture.
REQ-016 Capture SHALL, on one edge, load X<=sw_s[3:0], Y<=sw_s[7:4], set valid=1 for exactly that one following cycle, increment capture_count.
REQ-017 Latency: valid SHALL rise exactly 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after KEY1 falls and stays low, with no bounce.
REQ-018 HELD: key_s=1 -> DB_RELEASE with counter cleared; key_s=0 -> stay; holding never re-captures.
REQ-019 DB_RELEASE: key_s=1 -> counter+1; key_s=0 -> HELD, counter cleared, no capture.
REQ-020 DB_RELEASE: key_s=1 and counter = DEBOUNCE_CYCLES-1 -> IDLE.
REQ-021 X/Y SHALL hold their values between captures regardless of SW changes.
REQ-022 capture_count SHALL wrap 15 -> 0 with no flag or saturation.
REQ-023 busy SHALL be combinational decode of state (high in DB_PRESS, HELD, DB_RELEASE).
REQ-024 Debounce counter width SHALL be 20 bits; counter never exceeds DEBOUNCE_CYCLES-1.
REQ-025 Exactly one valid pulse SHALL be produced per debounced press/release cycle.

Reset
REQ-026 KEY0=0 SHALL immediately, without clock, force state=IDLE, counter=0, X=0, Y=0, valid=0, capture_count=0, synchronizer flops to KEY1=1 / SW=0.
REQ-027 Reset asserted mid-debounce or in HELD SHALL abort with no valid pulse; after release, a KEY1 still held low SHALL be treated as a new press (full debounce, then capture).
REQ-028 Reset deassertion SHALL be synchronized in the top level; the block assumes deassertion is clean relative to MAX10_CLK1_50.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 SW=8'h5A, KEY1 low steady -> valid one cycle at 7 cycles after fall; X=4'hA, Y=4'h5, capture_count=1.
REQ-030 KEY1 low 2 cycles, high 1, low steady -> counter restarts; single valid, X/Y per SW, count=1.
REQ-031 KEY1 held low 1000 cycles, SW toggled during hold -> one valid only; X/Y keep values from capture edge; busy=1 throughout.
REQ-032 Release bounce (high 2, low 1, high steady) -> returns to HELD then IDLE after 4 stable cycles; no extra valid; busy falls.
REQ-033 17 clean press/release cycles -> capture_count sequence 1..15,0,1; valid pulses = 17.
REQ-034 KEY0 pulsed low in DB_PRESS with count=2 -> all outputs 0 asynchronously, no valid; KEY1 still low after reset -> valid 7 cycles after reset release.

Source files
------------

// File: rtl/operand_latch.sv
// Captures two 4-bit operands from the switches on a debounced KEY1 press.
// One capture and one valid pulse happen per debounced press/release cycle.
module operand_latch #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic [7:0] SW,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       valid,
    output logic       busy,
    output logic [3:0] capture_count
);

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [19:0] cnt_reg, cnt_next;
    logic        capture;
    logic        key_meta_reg, key_s;
    logic [7:0]  sw_meta_reg, sw_s;
    logic [3:0]  x_reg, y_reg, count_reg;
    logic        valid_reg;

    // Key idles high, so its synchronizer resets to 1 to avoid a false press.
    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_meta_reg <= 1'b1;
            key_s        <= 1'b1;
        end else begin
            key_meta_reg <= KEY1;
            key_s        <= key_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sw_sync
            always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
                if (!KEY0) begin
                    sw_meta_reg[gi] <= 1'b0;
                    sw_s[gi]        <= 1'b0;
                end else begin
                    sw_meta_reg[gi] <= SW[gi];
                    sw_s[gi]        <= sw_meta_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!key_s) begin
                    state_next = DB_PRESS;
                    cnt_next   = '0;
                end
            end
            DB_PRESS: begin
                if (key_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 20'd1;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end
            end
            DB_RELEASE: begin
                if (!key_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 20'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            x_reg     <= '0;
            y_reg     <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= capture;
            if (capture) begin
                x_reg     <= sw_s[3:0];
                y_reg     <= sw_s[7:4];
                count_reg <= count_reg + 4'd1;
            end
        end
    end

    assign X             = x_reg;
    assign Y             = y_reg;
    assign valid         = valid_reg;
    assign capture_count = count_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_operand_latch.sv
// Bench for operand_latch with a short debounce window; a monitor checks each
// valid pulse against a queue of expected captures pushed by the stimulus.
module tb_operand_latch;

    localparam int D   = 4;
    localparam int LAT = 2 + D + 1;

    logic       clk;
    logic       rst_n;
    logic       key1;
    logic [7:0] sw;
    logic [3:0] x, y, cnt;
    logic       valid, busy;

    operand_latch #(.DEBOUNCE_CYCLES(D)) dut (
        .MAX10_CLK1_50(clk),
        .KEY0(rst_n),
        .KEY1(key1),
        .SW(sw),
        .X(x),
        .Y(y),
        .valid(valid),
        .busy(busy),
        .capture_count(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] ex, ey, ecnt;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_cycle", cyc, e.at);
                check("X", {28'd0, x}, {28'd0, e.ex});
                check("Y", {28'd0, y}, {28'd0, e.ey});
                check("capture_count", {28'd0, cnt}, {28'd0, e.ecnt});
                $display("capture at cycle %0d X=%h Y=%h count=%0d", cyc, x, y, cnt);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] v);
        exp_t e;
        sw   = v;
        key1 = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        e.at = cyc + LAT;
        e.ex = v[3:0];
        e.ey = v[7:4];
        e.ecnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic release_key();
        key1 = 1'b1;
        wait_cyc(2 + D + 3);
        check("busy_after_release", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_X"}, {28'd0, x}, 32'd0);
        check({tag, "_Y"}, {28'd0, y}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_count"}, {28'd0, cnt}, 32'd0);
    endtask

    initial begin
        int m;
        int busy_drops;
        rst_n = 1'b0;
        key1  = 1'b1;
        sw    = 8'h00;
        #1;
        check_all_zero("reset");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);

        // Clean press: capture 7 cycles after fall.
        check("busy_idle", {31'd0, busy}, 32'd0);
        press(8'h5A);
        wait_cyc(4);
        check("busy_db_press", {31'd0, busy}, 32'd1);
        wait_cyc(6);
        check("X_5A", {28'd0, x}, 32'hA);
        check("Y_5A", {28'd0, y}, 32'h5);
        release_key();

        // Press bounce restarts the debounce.
        sw = 8'h3C;
        key1 = 1'b0;
        wait_cyc(2);
        key1 = 1'b1;
        wait_cyc(1);
        press(8'h3C);
        wait_cyc(12);
        release_key();

        // Long hold with switch activity: one capture, X/Y frozen.
        press(8'h81);
        wait_cyc(10);
        busy_drops = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 7 == 0) sw = ~sw;
            if (busy !== 1'b1) busy_drops++;
            wait_cyc(1);
        end
        check("busy_during_hold", busy_drops, 0);
        check("X_hold", {28'd0, x}, 32'h1);
        check("Y_hold", {28'd0, y}, 32'h8);
        release_key();

        // Release bounce: back to HELD, then IDLE after D stable cycles.
        press(8'hF0);
        wait_cyc(10);
        key1 = 1'b1;
        m = cyc;
        wait_cyc(2);
        key1 = 1'b0;
        wait_cyc(1);
        key1 = 1'b1;
        wait_cyc(6);
        check("busy_release_bounce", {31'd0, busy}, 32'd1);
        check("release_bounce_cycle", cyc, m + 9);
        wait_cyc(1);
        check("busy_release_done", {31'd0, busy}, 32'd0);
        wait_cyc(5);

        // Counter wrap over 17 captures from a fresh reset.
        rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        check("count_reset", {28'd0, cnt}, 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 17; i++) begin
            press(8'(i * 37 + 1));
            wait_cyc(10);
            release_key();
        end
        check("count_wrapped", {28'd0, cnt}, 32'd1);

        // Reset mid-debounce aborts; key still low is a new press afterwards.
        sw = 8'hC3;
        key1 = 1'b0;
        wait_cyc(5);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        exp_cnt = '0;
        wait_cyc(3);
        rst_n = 1'b1;
        press(8'hC3);
        wait_cyc(12);
        release_key();

        check("pending_captures", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
